// File: rtl/seg7_led_writer_pkg.sv
// Shared constants, types and the segment pattern table for the LED / 7-segment bus writer.
package seg7_led_writer_pkg;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned PRESC_W    = 16;
  localparam int unsigned DOT_W      = 4;

  localparam logic [ADDR_W-1:0] LED_BASE_ADDR    = 8'hC0;
  localparam logic [ADDR_W-1:0] SEG_BASE_ADDR    = 8'hD0;
  localparam int unsigned       SCAN_DIV_DEFAULT = 50000;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [SEG_W-1:0] SEG_PATTERN [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_LED,
    SEL_DIG_LO,
    SEL_DIG_HI,
    SEL_DOT
  } reg_sel_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] data;
  } bus_req_t;

  function automatic logic [SEG_W-1:0] seg_pattern(input logic [NIBBLE_W-1:0] nibble);
    return SEG_PATTERN[nibble];
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to active-low seven-segment pattern, purely combinational.
module seg7_decoder
  import seg7_led_writer_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    seg_c
);

  assign seg_c = seg_pattern(nibble);

endmodule

// File: rtl/seg7_led_writer.sv
// Bus-write peripheral: LED register, 4-digit hex display register file with read-back,
// and a prescaled digit scanner driving a common-anode seven-segment display.
module seg7_led_writer
  import seg7_led_writer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LedBaseAddr = LED_BASE_ADDR,
  parameter logic [ADDR_W-1:0] SegBaseAddr = SEG_BASE_ADDR,
  parameter int unsigned       SCAN_DIV    = SCAN_DIV_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_W-1:0]     BUS_ADDR,
  input  logic                  BUS_WE,
  inout  wire  [DATA_W-1:0]     BUS_DATA,
  output logic [DATA_W-1:0]     LED_OUT,
  output logic [NUM_DIGITS-1:0] SEG_SELECT,
  output logic [DATA_W-1:0]     HEX_OUT
);

  localparam logic [ADDR_W-1:0]  SEG_HI_ADDR = SegBaseAddr + ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  DOT_ADDR    = SegBaseAddr + ADDR_W'(2);
  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(SCAN_DIV - 1);

  bus_req_t                         req;
  reg_sel_e                         sel;
  logic [DATA_W-1:0]                led_reg;
  logic [NUM_DIGITS*NIBBLE_W-1:0]   digits;
  logic [DOT_W-1:0]                 dot_mask;
  logic                             read_en;
  logic [DATA_W-1:0]                read_data;
  logic [DATA_W-1:0]                read_mux_c;
  logic [PRESC_W-1:0]               presc;
  logic [IDX_W-1:0]                 digit_idx;
  logic [NIBBLE_W-1:0]              cur_nibble_c;
  logic [SEG_W-1:0]                 cur_seg_c;

  assign req = '{addr: BUS_ADDR, we: BUS_WE, data: BUS_DATA};

  // Address decode; anything outside the four mapped registers selects nothing.
  always_comb begin
    sel = SEL_NONE;
    if (req.addr == LedBaseAddr) begin
      sel = SEL_LED;
    end else if (req.addr == SegBaseAddr) begin
      sel = SEL_DIG_LO;
    end else if (req.addr == SEG_HI_ADDR) begin
      sel = SEL_DIG_HI;
    end else if (req.addr == DOT_ADDR) begin
      sel = SEL_DOT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      led_reg  <= '0;
      digits   <= '0;
      dot_mask <= '0;
    end else if (req.we) begin
      case (sel)
        SEL_LED:    led_reg       <= req.data;
        SEL_DIG_LO: digits[7:0]   <= req.data;
        SEL_DIG_HI: digits[15:8]  <= req.data;
        SEL_DOT:    dot_mask      <= req.data[DOT_W-1:0];
        default:    ;
      endcase
    end
  end

  assign LED_OUT = led_reg;

  always_comb begin
    read_mux_c = '0;
    case (sel)
      SEL_LED:    read_mux_c = led_reg;
      SEL_DIG_LO: read_mux_c = digits[7:0];
      SEL_DIG_HI: read_mux_c = digits[15:8];
      SEL_DOT:    read_mux_c = {(DATA_W - DOT_W)'(0), dot_mask};
      default:    read_mux_c = '0;
    endcase
  end

  // Read data is captured one cycle after the address and held on the bus for that cycle only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      read_en   <= 1'b0;
      read_data <= '0;
    end else begin
      read_en <= !req.we && (sel != SEL_NONE);
      if (!req.we && (sel != SEL_NONE)) begin
        read_data <= read_mux_c;
      end
    end
  end

  assign BUS_DATA = read_en ? read_data : {DATA_W{1'bz}};

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc     <= '0;
      digit_idx <= '0;
    end else if (presc == PRESC_LAST) begin
      presc     <= '0;
      digit_idx <= digit_idx + IDX_W'(1);
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  assign cur_nibble_c = digits[{digit_idx, 2'b00} +: NIBBLE_W];

  seg7_decoder u_decoder (
    .nibble (cur_nibble_c),
    .seg_c  (cur_seg_c)
  );

  // Registered display drive; lags digit_idx and register writes by one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      SEG_SELECT <= ~NUM_DIGITS'(1);
      HEX_OUT    <= {1'b1, seg_pattern(NIBBLE_W'(0))};
    end else begin
      SEG_SELECT <= ~(NUM_DIGITS'(1) << digit_idx);
      HEX_OUT    <= {~dot_mask[digit_idx], cur_seg_c};
    end
  end

endmodule

// File: tb/tb_seg7_led_writer.sv
// Directed bench for seg7_led_writer with a fast scan divider.
module tb_seg7_led_writer;

  localparam int unsigned SCAN_DIV = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  wire  [7:0] BUS_DATA;
  logic [7:0] LED_OUT;
  logic [3:0] SEG_SELECT;
  logic [7:0] HEX_OUT;

  logic       drv;
  logic [7:0] drv_data;
  wire        bus_z;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit scan_on = 1'b0;

  logic [7:0] exp_hex [4];
  logic [3:0] seg_tab [4];

  assign BUS_DATA = drv ? drv_data : 8'hzz;
  assign bus_z    = (BUS_DATA === 8'hzz);

  always #5 CLK = ~CLK;

  seg7_led_writer #(
    .LedBaseAddr (8'hC0),
    .SegBaseAddr (8'hD0),
    .SCAN_DIV    (SCAN_DIV)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BUS_ADDR   (BUS_ADDR),
    .BUS_WE     (BUS_WE),
    .BUS_DATA   (BUS_DATA),
    .LED_OUT    (LED_OUT),
    .SEG_SELECT (SEG_SELECT),
    .HEX_OUT    (HEX_OUT)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; checks reset values on a reset edge, otherwise the expected scan position.
  task automatic tick();
    logic was_rst;
    int   idx;
    @(posedge CLK);
    was_rst = RST;
    if (was_rst) cyc = 0;
    else cyc++;
    #1;
    if (was_rst) begin
      chk("rst_sel", {4'h0, SEG_SELECT}, 8'h0E);
      chk("rst_hex", HEX_OUT, 8'hC0);
      chk("rst_led", LED_OUT, 8'h00);
      chk("rst_bus_z", {7'h0, bus_z}, 8'h01);
    end else if (scan_on) begin
      idx = ((cyc - 1) / SCAN_DIV) % 4;
      chk("scan_sel", {4'h0, SEG_SELECT}, {4'h0, seg_tab[idx]});
      chk("scan_hex", HEX_OUT, exp_hex[idx]);
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    BUS_ADDR = addr;
    BUS_WE   = 1'b1;
    drv      = 1'b1;
    drv_data = data;
    tick();
  endtask

  task automatic rd(input logic [7:0] addr);
    BUS_ADDR = addr;
    BUS_WE   = 1'b0;
    drv      = 1'b0;
    tick();
  endtask

  task automatic idle();
    BUS_ADDR = 8'h00;
    BUS_WE   = 1'b0;
    drv      = 1'b0;
  endtask

  initial begin
    int guard;
    seg_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_hex  = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
    RST      = 1'b1;
    drv_data = 8'h00;
    idle();

    // Reset held for two cycles.
    tick();
    tick();
    RST     = 1'b0;
    scan_on = 1'b1;

    // LED write and read-back with one-cycle read latency.
    wr(8'hC0, 8'hA5);
    chk("led_after_wr", LED_OUT, 8'hA5);
    BUS_ADDR = 8'hC0;
    BUS_WE   = 1'b0;
    drv      = 1'b0;
    #1;
    chk("bus_z_before_rd", {7'h0, bus_z}, 8'h01);
    tick();
    chk("rd_led_driven", {7'h0, bus_z}, 8'h00);
    chk("rd_led_data", BUS_DATA, 8'hA5);
    idle();
    tick();
    chk("bus_released", {7'h0, bus_z}, 8'h01);
    chk("led_held", LED_OUT, 8'hA5);

    // Digits 4321 scanned from a fresh reset, 4 cycles per digit.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    wr(8'hD0, 8'h21);
    exp_hex = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
    wr(8'hD1, 8'h43);
    idle();
    repeat (18) tick();
    chk("wrap_digit0_sel", {4'h0, SEG_SELECT}, 8'h0E);
    chk("wrap_digit0_hex", HEX_OUT, 8'hF9);

    // Dot mask: all dp lit, read back zero-extended.
    wr(8'hD2, 8'hFF);
    exp_hex = '{8'h79, 8'h24, 8'h30, 8'h19};
    rd(8'hD2);
    chk("rd_dot_data", BUS_DATA, 8'h0F);
    idle();
    repeat (14) tick();
    chk("dp_digit0_hex", HEX_OUT, 8'h79);

    // Unmapped addresses never drive the bus and ignore writes.
    rd(8'hD3);
    chk("rd_d3_z", {7'h0, bus_z}, 8'h01);
    rd(8'h7F);
    chk("rd_7f_z", {7'h0, bus_z}, 8'h01);
    wr(8'hD3, 8'h55);
    idle();
    tick();
    chk("led_unchanged", LED_OUT, 8'h00);
    rd(8'hD0);
    chk("rd_d0", BUS_DATA, 8'h21);
    rd(8'hD1);
    chk("rd_d1", BUS_DATA, 8'h43);
    rd(8'hD2);
    chk("rd_d2", BUS_DATA, 8'h0F);
    rd(8'hC0);
    chk("rd_c0", BUS_DATA, 8'h00);
    idle();

    // Reset in the middle of the scan while digit 2 is selected internally.
    wr(8'hC0, 8'h3C);
    idle();
    chk("led_3c", LED_OUT, 8'h3C);
    guard = 0;
    while ((((cyc / SCAN_DIV) % 4) != 2) && (guard < 64)) begin
      tick();
      guard++;
    end
    total++;
    if (guard >= 64) begin
      bad++;
      $error("FAIL wait_digit2: observed=timeout expected=digit_idx 2");
    end
    RST = 1'b1;
    tick();
    RST     = 1'b0;
    exp_hex = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
    repeat (8) tick();
    chk("post_rst_sel", {4'h0, SEG_SELECT}, 8'h0D);
    chk("post_rst_led", LED_OUT, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
